load_arbiter: RTL and testbench
===============================

// Module: load_arbiter
// PURPOSE
//  Sequences ioctl download bytes, already classified by the download decoder, into one shared
//  single-port memory holding the image, palette and ROM regions. Shares that port with the
//  runtime video fetcher. Stalls ioctl while the port is busy. Holds the core in reset until a
//  complete, size-checked load has drained. Sits between the decoder/ioctl and the memory.
// PARAMETERS
//  AW        25          memory/ioctl address width
//  IMG_BASE  25'h000000  memory base of image region
//  PAL_BASE  25'h100000  memory base of palette region
//  ROM_BASE  25'h100300  memory base of ROM region
//  PAL_LEN   768         required palette byte count
//  ROM_LEN   4096        required ROM byte count
// PORTS
//  clk_sys         in   1   system clock (only clock)
//  reset_n         in   1   asynchronous active-low reset
//  ioctl_download  in   1   download active
//  dl_strobe       in   1   new download byte this cycle (decoder address-change pulse)
//  dl_data         in   8   download byte
//  rel_addr        in   AW  decoder region-relative address
//  sel_conf/sel_img/sel_pal/sel_rom  in  1 each  decoder region flags (at most one high)
//  ioctl_wait      out  1   stall upstream; high while holding register full
//  mem_req         out  1   memory request; held until mem_ack
//  mem_we          out  1   1=write, 0=read; stable while mem_req
//  mem_addr        out  AW  memory address
//  mem_wdata       out  8   write data
//  mem_ack         in   1   1-cycle completion pulse, >=1 cycle after req
//  mem_rdata       in   8   read data, valid with mem_ack
//  vid_req         in   1   video read request; held until vid_ack
//  vid_addr        in   AW  video read address
//  vid_ack         out  1   1-cycle pulse; vid_data valid this cycle
//  vid_data        out  8   read data to video
//  core_reset      out  1   hold core in reset
//  load_done       out  1   valid load present
//  load_error      out  1   sticky: overrun or bad size; cleared at next download start
// BEHAVIOUR
//  Reset values: all outputs 0 except core_reset=1. Holding register empty, counters 0, state BOOT.
//  States:
//   BOOT: core_reset=1. Download rise -> LOAD.
//   LOAD: core_reset=1, load_done=0. On entry, clear counters and load_error.
//   DRAIN: on download fall, go here. Wait for an empty holding register and no outstanding request.
//          If pal_cnt==PAL_LEN and rom_cnt==ROM_LEN: RUN.
//          Else: set load_error and go to BOOT.
//   RUN: load_done=1, core_reset=0 on the cycle after entry. Download rise -> LOAD
//        (core_reset=1 next cycle, load_done=0).
//  Capture: dl_strobe with sel_img/pal/rom loads the holding register.
//   - addr = base + rel_addr, truncated to AW bits (wraps mod 2^AW).
//   - pal_cnt/rom_cnt increment on capture (16-bit saturating).
//   - sel_conf bytes, or bytes with no flag set, are discarded and not written.
//  Overrun: dl_strobe while the holding register is full drops the byte and sets load_error.
//  ioctl_wait = holding register full, combinational from the register.
//  Arbitration: one transaction outstanding at a time. A grant is issued only when the port is idle.
//   - In LOAD/DRAIN: a pending write beats vid_req.
//   - In RUN: only video is granted. Writes are impossible in RUN.
//   - In BOOT: video is also served (pre-load reads return memory contents).
//   - A video read in flight at download rise completes normally (vid_ack still pulses); the first
//     write issues after it.
//  Latency: grant registers mem_req the cycle after request is seen.
//   - Write: register frees on the mem_ack cycle; a new capture is possible the same cycle.
//   - Read: vid_ack and vid_data are registered, one cycle after mem_ack.
//   - vid_req must stay high until vid_ack. A new read can be granted the cycle after vid_ack.
//  Simultaneous: dl_strobe on the same cycle as mem_ack freeing the register is accepted (no overrun).
//   Download fall while a write is pending: the write completes in DRAIN.
//  Reset mid-operation: asynchronous, returns everything to reset values immediately. An outstanding
//   memory transaction is abandoned; the memory must tolerate mem_req dropping.
// STRUCTURE
//  Package load_pkg: state enum (BOOT, LOAD, DRAIN, RUN), region base constants, PAL_LEN, ROM_LEN.
//  Sub-module: mem_port_arb, the 2-requester single-outstanding arbiter (priority input, req/ack
//   per side). The FSM, holding register and counters stay in load_arbiter.
// TESTING
//  1 Reset, then download 768 pal + 4096 rom bytes, mem_ack 2 cycles after req -> writes at
//    PAL_BASE..+767 and ROM_BASE..+4095; load_done=1, core_reset=0 after DRAIN; load_error=0.
//  2 Download with 4095 rom bytes -> load_error=1, state BOOT, core_reset stays 1.
//  3 mem_ack delayed 10 cycles, dl_strobe every cycle regardless of ioctl_wait -> load_error=1,
//    dropped bytes never written.
//  4 In RUN, vid_req at addr 0x100010 with memory holding 0x5A -> vid_ack 1 cycle after mem_ack,
//    vid_data=0x5A; held vid_req yields back-to-back reads.
//  5 vid read outstanding when download rises -> vid_ack still pulses; first write follows;
//    core_reset=1 the next cycle.
//  6 Assert reset_n=0 mid-LOAD with mem_req high -> outputs at reset values the same cycle;
//    rel_addr wrap at 2^25-1 produces a truncated address.

Source files
------------

// File: rtl/load_pkg.sv
// Shared types and defaults for the download loader.
// Region bases, required sizes and the loader state encoding.
package load_pkg;

  localparam int DEF_AW = 25;
  localparam int CNT_W  = 16;

  localparam logic [DEF_AW-1:0] DEF_IMG_BASE = 25'h000000;
  localparam logic [DEF_AW-1:0] DEF_PAL_BASE = 25'h100000;
  localparam logic [DEF_AW-1:0] DEF_ROM_BASE = 25'h100300;

  localparam int DEF_PAL_LEN = 768;
  localparam int DEF_ROM_LEN = 4096;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_LOAD,
    ST_DRAIN,
    ST_RUN
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Two-requester, single-outstanding arbiter for the shared memory port.
// Side A writes (wins when prio_a), side B reads with a registered ack.
module mem_port_arb #(
  parameter int AW = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prio_a,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_ack,
  output logic [7:0]    b_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata
);

  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          b_ack_q, b_ack_d;
  logic [7:0]    b_data_q, b_data_d;
  logic          b_ok, gnt_a, gnt_b, done;

  always_comb begin
    // B still holds its request during its ack cycle; don't reissue it
    b_ok     = b_req & ~b_ack_q;
    gnt_a    = ~req_q & a_req & (prio_a | ~b_ok);
    gnt_b    = ~req_q & b_ok & ~gnt_a;
    done     = req_q & mem_ack;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    b_ack_d  = done & ~we_q;
    b_data_d = b_ack_d ? mem_rdata : b_data_q;
    if (done) req_d = 1'b0;
    unique case (1'b1)
      gnt_a: begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = a_addr;
        wdata_d = a_wdata;
      end
      gnt_b: begin
        req_d  = 1'b1;
        we_d   = 1'b0;
        addr_d = b_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      b_ack_q  <= 1'b0;
      b_data_q <= '0;
    end else begin
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      b_ack_q  <= b_ack_d;
      b_data_q <= b_data_d;
    end
  end

  assign a_ack     = done & we_q;
  assign b_ack     = b_ack_q;
  assign b_data    = b_data_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: rtl/load_arbiter.sv
// Sequences classified ioctl bytes into the shared memory and gates
// core reset until a complete, size-checked image has drained.
module load_arbiter
  import load_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter logic [AW-1:0] IMG_BASE = DEF_IMG_BASE,
  parameter logic [AW-1:0] PAL_BASE = DEF_PAL_BASE,
  parameter logic [AW-1:0] ROM_BASE = DEF_ROM_BASE,
  parameter int            PAL_LEN  = DEF_PAL_LEN,
  parameter int            ROM_LEN  = DEF_ROM_LEN
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          dl_strobe,
  input  logic [7:0]    dl_data,
  input  logic [AW-1:0] rel_addr,
  input  logic          sel_conf,
  input  logic          sel_img,
  input  logic          sel_pal,
  input  logic          sel_rom,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_data,
  output logic          core_reset,
  output logic          load_done,
  output logic          load_error
);

  state_e             state_q, state_d;
  logic               dl_q;
  logic               hold_vld_q, hold_vld_d;
  logic [AW-1:0]      hold_addr_q, hold_addr_d;
  logic [7:0]         hold_data_q, hold_data_d;
  logic [CNT_W-1:0]   pal_cnt_q, pal_cnt_d;
  logic [CNT_W-1:0]   rom_cnt_q, rom_cnt_d;
  logic               err_q, err_d;
  logic               core_reset_q, core_reset_d;
  logic               done_q, done_d;
  logic               dl_rise, dl_fall, wr_phase;
  logic               cap, take, wr_ack, size_ok, stay_run;
  logic [AW-1:0]      base;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign wr_phase = (state_q == ST_LOAD) | (state_q == ST_DRAIN);
  assign cap      = (state_q == ST_LOAD) & dl_strobe & ~sel_conf
                  & (sel_img | sel_pal | sel_rom);
  // the register may refill on the same cycle its write completes
  assign take     = cap & (~hold_vld_q | wr_ack);
  assign size_ok  = (pal_cnt_q == CNT_W'(PAL_LEN))
                  & (rom_cnt_q == CNT_W'(ROM_LEN));

  always_comb begin
    unique case (1'b1)
      sel_pal: base = PAL_BASE;
      sel_rom: base = ROM_BASE;
      default: base = IMG_BASE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hold_vld_d  = hold_vld_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    pal_cnt_d   = pal_cnt_q;
    rom_cnt_d   = rom_cnt_q;
    err_d       = err_q;
    if (wr_ack) hold_vld_d = 1'b0;
    if (take) begin
      hold_vld_d  = 1'b1;
      hold_addr_d = base + rel_addr;
      hold_data_d = dl_data;
      if (sel_pal) pal_cnt_d = sat_inc(pal_cnt_q);
      if (sel_rom) rom_cnt_d = sat_inc(rom_cnt_q);
    end
    if (cap && !take) err_d = 1'b1;
    unique case (state_q)
      ST_BOOT, ST_RUN: begin
        if (dl_rise) begin
          state_d   = ST_LOAD;
          pal_cnt_d = '0;
          rom_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      ST_LOAD: begin
        if (dl_fall) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!hold_vld_q && !mem_req) begin
          if (size_ok) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_BOOT;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
    stay_run     = (state_q == ST_RUN) & (state_d == ST_RUN);
    core_reset_d = ~stay_run;
    done_d       = stay_run;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      dl_q         <= 1'b0;
      hold_vld_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      pal_cnt_q    <= '0;
      rom_cnt_q    <= '0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      hold_vld_q   <= hold_vld_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      pal_cnt_q    <= pal_cnt_d;
      rom_cnt_q    <= rom_cnt_d;
      err_q        <= err_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
    end
  end

  mem_port_arb #(
    .AW (AW)
  ) u_arb (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .prio_a    (wr_phase),
    .a_req     (hold_vld_q),
    .a_addr    (hold_addr_q),
    .a_wdata   (hold_data_q),
    .a_ack     (wr_ack),
    .b_req     (vid_req),
    .b_addr    (vid_addr),
    .b_ack     (vid_ack),
    .b_data    (vid_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  assign ioctl_wait = hold_vld_q;
  assign core_reset = core_reset_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_load_arbiter.sv
// Randomized bench for load_arbiter with a behavioural memory and
// a reference list of expected writes built from the byte stream.
module tb_load_arbiter;

  localparam logic [24:0] IMG_B = 25'h000000;
  localparam logic [24:0] PAL_B = 25'h100000;
  localparam logic [24:0] ROM_B = 25'h100300;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        dl_strobe = 1'b0;
  logic [7:0]  dl_data = '0;
  logic [24:0] rel_addr = '0;
  logic        sel_conf = 1'b0;
  logic        sel_img = 1'b0;
  logic        sel_pal = 1'b0;
  logic        sel_rom = 1'b0;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        vid_req = 1'b0;
  logic [24:0] vid_addr = '0;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic        core_reset;
  logic        load_done;
  logic        load_error;

  load_arbiter dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .dl_strobe      (dl_strobe),
    .dl_data        (dl_data),
    .rel_addr       (rel_addr),
    .sel_conf       (sel_conf),
    .sel_img        (sel_img),
    .sel_pal        (sel_pal),
    .sel_rom        (sel_rom),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .vid_req        (vid_req),
    .vid_addr       (vid_addr),
    .vid_ack        (vid_ack),
    .vid_data       (vid_data),
    .core_reset     (core_reset),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int tmo = 0;

  int          ack_dly = 2;
  logic [7:0]  mem [int];
  logic [24:0] wr_a_q [$];
  logic [7:0]  wr_d_q [$];
  int          wr_c_q [$];
  int          ack_cyc = 0;
  logic [24:0] ex_a_q [$];
  logic [7:0]  ex_d_q [$];
  logic [7:0]  rom_d [4096];

  // memory model: acks ack_dly cycles after it first sees mem_req
  initial begin : responder
    bit busy;
    int cnt;
    busy = 0;
    cnt = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      mem_ack = 1'b0;
      if (!reset_n) begin
        busy = 0;
        cnt = 0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1;
          cnt = 0;
        end
        cnt++;
        if (cnt >= ack_dly) begin
          mem_ack = 1'b1;
          busy = 0;
          ack_cyc = cyc;
          if (mem_we) begin
            mem[int'(mem_addr)] = mem_wdata;
            wr_a_q.push_back(mem_addr);
            wr_d_q.push_back(mem_wdata);
            wr_c_q.push_back(cyc);
          end else begin
            mem_rdata = mem.exists(int'(mem_addr)) ?
                        mem[int'(mem_addr)] : 8'h00;
          end
        end
      end
    end
  end

  function automatic logic [24:0] exp_addr(input int s,
                                           input logic [24:0] rel);
    longint b;
    b = (s == 2) ? longint'(PAL_B) :
        (s == 3) ? longint'(ROM_B) : longint'(IMG_B);
    return 25'((b + longint'(rel)) % longint'(33554432));
  endfunction

  function automatic int write_diffs();
    int n;
    n = 0;
    if (wr_a_q.size() != ex_a_q.size()) n++;
    for (int i = 0; i < wr_a_q.size() && i < ex_a_q.size(); i++)
      if (wr_a_q[i] !== ex_a_q[i] || wr_d_q[i] !== ex_d_q[i]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_sel(input int s);
    sel_conf = (s == 0);
    sel_img  = (s == 1);
    sel_pal  = (s == 2);
    sel_rom  = (s == 3);
  endtask

  task automatic clear_logs();
    wr_a_q.delete();
    wr_d_q.delete();
    wr_c_q.delete();
    ex_a_q.delete();
    ex_d_q.delete();
  endtask

  task automatic expect_wr(input int s, input logic [24:0] rel,
                           input logic [7:0] d);
    ex_a_q.push_back(exp_addr(s, rel));
    ex_d_q.push_back(d);
  endtask

  task automatic send_byte(input int s, input logic [24:0] rel,
                           input logic [7:0] d, input bit honor);
    int n;
    n = 0;
    while (honor && ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) tmo++;
    set_sel(s);
    rel_addr  = rel;
    dl_data   = d;
    dl_strobe = 1'b1;
    tick();
    dl_strobe = 1'b0;
    set_sel(4);
  endtask

  // occasional conf / unflagged / image bytes mixed into the stream
  task automatic maybe_noise();
    int s;
    logic [24:0] r;
    logic [7:0] d;
    if ($urandom_range(0, 7) == 0) begin
      s = $urandom_range(0, 2);
      if (s == 2) s = 4;
      r = 25'($urandom_range(0, 1023));
      d = 8'($urandom);
      send_byte(s, r, d, 1);
      if (s == 1) expect_wr(1, r, d);
    end
  endtask

  task automatic run_download(input int np, input int nr, input int ad);
    logic [7:0] d;
    ack_dly = ad;
    clear_logs();
    ioctl_download = 1'b1;
    tick();
    tick();
    for (int i = 0; i < np; i++) begin
      maybe_noise();
      d = (i == 16) ? 8'h5A : 8'($urandom);
      send_byte(2, 25'(i), d, 1);
      expect_wr(2, 25'(i), d);
    end
    for (int i = 0; i < nr; i++) begin
      maybe_noise();
      d = 8'($urandom);
      rom_d[i] = d;
      send_byte(3, 25'(i), d, 1);
      expect_wr(3, 25'(i), d);
    end
    ioctl_download = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    n_chk++;
    if (core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_core_reset got %b want 1", core_reset);
    end
    n_chk++;
    if ({load_done, load_error, mem_req, ioctl_wait, vid_ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 00000",
               {load_done, load_error, mem_req, ioctl_wait, vid_ack});
    end
    reset_n = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({core_reset, load_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL boot_idle got %b want 10", {core_reset, load_done});
    end
  endtask

  task automatic test_full_load();
    int t0, nd;
    t0 = tmo;
    run_download(768, 4096, 2);
    nd = write_diffs();
    n_chk++;
    if (wr_a_q.size() !== ex_a_q.size()) begin
      n_fail++;
      $display("FAIL full_wr_count got %0d want %0d",
               wr_a_q.size(), ex_a_q.size());
    end
    n_chk++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL full_wr_content got %0d diffs want 0", nd);
    end
    n_chk++;
    if ({load_done, core_reset, load_error} !== 3'b100) begin
      n_fail++;
      $display("FAIL full_status got %b want 100",
               {load_done, core_reset, load_error});
    end
    n_chk++;
    if (tmo !== t0) begin
      n_fail++;
      $display("FAIL full_wait_timeout got %0d want %0d", tmo, t0);
    end
  endtask

  task automatic test_video_read();
    int n, acks;
    ack_dly = 2;
    vid_addr = PAL_B + 25'h10;
    vid_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!vid_ack && n < 50);
    n_chk++;
    if (vid_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL vid_ack1 got %b want 1", vid_ack);
    end
    n_chk++;
    if (vid_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL vid_data1 got %h want 5a", vid_data);
    end
    n_chk++;
    if (cyc - ack_cyc !== 1) begin
      n_fail++;
      $display("FAIL vid_latency got %0d want 1", cyc - ack_cyc);
    end
    vid_addr = ROM_B;
    n = 0;
    do begin
      tick();
      n++;
    end while (!vid_ack && n < 50);
    n_chk++;
    if (vid_ack !== 1'b1 || vid_data !== rom_d[0]) begin
      n_fail++;
      $display("FAIL vid_b2b got ack=%b data=%h want ack=1 data=%h",
               vid_ack, vid_data, rom_d[0]);
    end
    vid_req = 1'b0;
    acks = 0;
    repeat (8) begin
      tick();
      if (vid_ack) acks++;
    end
    n_chk++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL vid_extra_ack got %0d want 0", acks);
    end
  endtask

  task automatic test_read_at_rise();
    int n, va_cyc;
    ack_dly = 6;
    clear_logs();
    vid_addr = ROM_B + 25'd5;
    vid_req = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    ioctl_download = 1'b1;
    tick();
    n_chk++;
    if (core_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_core_reset got %b want 1", core_reset);
    end
    send_byte(2, 25'd7, 8'hC3, 1);
    expect_wr(2, 25'd7, 8'hC3);
    n = 0;
    while (!vid_ack && n < 30) begin
      tick();
      n++;
    end
    va_cyc = cyc;
    n_chk++;
    if (vid_ack !== 1'b1 || vid_data !== rom_d[5]) begin
      n_fail++;
      $display("FAIL rise_vid got ack=%b data=%h want ack=1 data=%h",
               vid_ack, vid_data, rom_d[5]);
    end
    vid_req = 1'b0;
    n = 0;
    while (wr_a_q.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    n_chk++;
    if (write_diffs() !== 0) begin
      n_fail++;
      $display("FAIL rise_write got %0d writes want 1 at %h",
               wr_a_q.size(), ex_a_q[0]);
    end
    n_chk++;
    if (wr_c_q.size() == 0 || wr_c_q[0] <= va_cyc) begin
      n_fail++;
      $display("FAIL rise_order got write before or without read (%0d)",
               va_cyc);
    end
    ioctl_download = 1'b0;
    repeat (20) tick();
    n_chk++;
    if ({load_error, core_reset, load_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL rise_short_status got %b want 110",
               {load_error, core_reset, load_done});
    end
  endtask

  task automatic test_short_rom();
    int nd;
    run_download(768, 4095, 1);
    nd = write_diffs();
    n_chk++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL short_wr_content got %0d diffs want 0", nd);
    end
    n_chk++;
    if ({load_error, core_reset, load_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL short_status got %b want 110",
               {load_error, core_reset, load_done});
    end
  endtask

  task automatic test_overrun();
    logic [7:0] sd [40];
    int nd;
    ack_dly = 10;
    clear_logs();
    ioctl_download = 1'b1;
    tick();
    tick();
    n_chk++;
    if (load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_err_clear got %b want 0", load_error);
    end
    for (int i = 0; i < 40; i++) begin
      sd[i] = 8'($urandom);
      send_byte(2, 25'(i), sd[i], 0);
    end
    // capture, grant, 10-cycle ack, refill on the ack cycle: period 11
    for (int i = 0; i < 40; i += 11) expect_wr(2, 25'(i), sd[i]);
    n_chk++;
    if (load_error !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_err_set got %b want 1", load_error);
    end
    ioctl_download = 1'b0;
    repeat (40) tick();
    nd = write_diffs();
    n_chk++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL ovr_writes got %0d writes (%0d diffs) want %0d",
               wr_a_q.size(), nd, ex_a_q.size());
    end
    n_chk++;
    if ({load_error, load_done} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr_status got %b want 10", {load_error, load_done});
    end
  endtask

  task automatic test_reset_mid();
    int n, nd;
    ack_dly = 10;
    clear_logs();
    ioctl_download = 1'b1;
    tick();
    tick();
    send_byte(3, 25'd0, 8'h11, 1);
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    n_chk++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_req got %b want 1", mem_req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({mem_req, mem_we, ioctl_wait, vid_ack, load_done, load_error,
         core_reset} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl got %b want 0000001",
               {mem_req, mem_we, ioctl_wait, vid_ack, load_done,
                load_error, core_reset});
    end
    n_chk++;
    if ({mem_addr, mem_wdata, vid_data} !== 41'b0) begin
      n_fail++;
      $display("FAIL rst_mid_data got %h %h %h want 0",
               mem_addr, mem_wdata, vid_data);
    end
    ioctl_download = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    ack_dly = 2;
    clear_logs();
    ioctl_download = 1'b1;
    tick();
    tick();
    send_byte(3, 25'h1FFFFFF, 8'hA5, 1);
    expect_wr(3, 25'h1FFFFFF, 8'hA5);
    send_byte(1, 25'h1FFFFFF, 8'h3C, 1);
    expect_wr(1, 25'h1FFFFFF, 8'h3C);
    send_byte(2, 25'h1FFFFFF, 8'h96, 1);
    expect_wr(2, 25'h1FFFFFF, 8'h96);
    repeat (20) tick();
    nd = write_diffs();
    n_chk++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL wrap_writes got %0d diffs want 0", nd);
    end
    n_chk++;
    if (wr_a_q.size() == 0 || wr_a_q[0] !== 25'h1002FF) begin
      n_fail++;
      $display("FAIL wrap_rom_addr got %0d writes want first at 1002ff",
               wr_a_q.size());
    end
    ioctl_download = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    set_sel(4);
    test_reset();
    test_full_load();
    test_video_read();
    test_read_at_rise();
    test_short_rom();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
